// File: rtl/bus_mux_if.sv
// Bus-mux signal bundle: source selects and data in, bus value, status and counters out.
// The master side drives selects/data, the slave side (the mux) drives results.
interface bus_mux_if #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int SELW = 3,
  parameter int CNTW = 8
);
  logic [DW-1:0]      din;
  logic [DW-1:0]      aluout;
  logic [NREG*DW-1:0] regs;
  logic               din_en;
  logic               gout;
  logic               rout_en;
  logic [SELW-1:0]    rout;
  logic               clr_err;
  logic [DW-1:0]      buswires;
  logic [DW-1:0]      bus_q;
  logic               bus_vld;
  logic [1:0]         src_q;
  logic [SELW-1:0]    idx_q;
  logic               conflict;
  logic               range_err;
  logic [CNTW-1:0]    conf_cnt;

  modport master (
    output din, aluout, regs, din_en, gout, rout_en, rout, clr_err,
    input  buswires, bus_q, bus_vld, src_q, idx_q, conflict, range_err, conf_cnt
  );
  modport slave (
    input  din, aluout, regs, din_en, gout, rout_en, rout, clr_err,
    output buswires, bus_q, bus_vld, src_q, idx_q, conflict, range_err, conf_cnt
  );
endinterface

// File: rtl/bus_mux_reg.sv
// Fixed-priority datapath bus mux (din > alu > reg) with a registered, holding bus copy,
// source tag, sticky conflict/range flags and a saturating conflict counter.
module bus_mux_reg #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int SELW = 3,
  parameter int CNTW = 8
) (
  input logic      clk,
  input logic      rst,
  bus_mux_if.slave bus
);
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_DIN  = 2'd1;
  localparam logic [1:0] SRC_ALU  = 2'd2;
  localparam logic [1:0] SRC_REG  = 2'd3;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [SELW:0]   NREG_W  = (SELW+1)'(NREG);

  logic [NREG-1:0][DW-1:0] reg_arr;
  logic [DW-1:0]           reg_sel, bus_d;
  logic [1:0]              src_d, n_en;
  logic                    any_en, conf_now, range_now;

  logic [DW-1:0]   bus_r;
  logic            vld_r, conflict_r, range_r;
  logic [1:0]      src_r;
  logic [SELW-1:0] idx_r;
  logic [CNTW-1:0] cnt_r, cnt_base;

  for (genvar i = 0; i < NREG; i++) begin : g_unpack
    assign reg_arr[i] = bus.regs[i*DW +: DW];
  end

  // Matching-index mux: an out-of-range rout matches nothing and yields 0.
  always_comb begin
    reg_sel = '0;
    for (int i = 0; i < NREG; i++)
      if (bus.rout == SELW'(i)) reg_sel = reg_arr[i];
  end

  assign n_en      = {1'b0, bus.din_en} + {1'b0, bus.gout} + {1'b0, bus.rout_en};
  assign any_en    = bus.din_en | bus.gout | bus.rout_en;
  assign conf_now  = (n_en >= 2'd2);
  assign range_now = bus.rout_en & ({1'b0, bus.rout} >= NREG_W);

  always_comb begin
    bus_d = '0;
    src_d = SRC_NONE;
    if (bus.din_en) begin
      bus_d = bus.din;
      src_d = SRC_DIN;
    end else if (bus.gout) begin
      bus_d = bus.aluout;
      src_d = SRC_ALU;
    end else if (bus.rout_en) begin
      bus_d = reg_sel;
      src_d = SRC_REG;
    end
  end

  // A clear in the same cycle as a new error restarts the count at 1.
  assign cnt_base = bus.clr_err ? '0 : cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r      <= '0;
      vld_r      <= 1'b0;
      src_r      <= SRC_NONE;
      idx_r      <= '0;
      conflict_r <= 1'b0;
      range_r    <= 1'b0;
      cnt_r      <= '0;
    end else begin
      vld_r <= any_en;
      if (any_en) begin
        bus_r <= bus_d;
        src_r <= src_d;
        idx_r <= (src_d == SRC_REG) ? bus.rout : '0;
      end
      conflict_r <= (conflict_r & ~bus.clr_err) | conf_now;
      range_r    <= (range_r & ~bus.clr_err) | range_now;
      if (conf_now && cnt_base != CNT_MAX) cnt_r <= cnt_base + 1'b1;
      else                                 cnt_r <= cnt_base;
    end
  end

  assign bus.buswires  = bus_d;
  assign bus.bus_q     = bus_r;
  assign bus.bus_vld   = vld_r;
  assign bus.src_q     = src_r;
  assign bus.idx_q     = idx_r;
  assign bus.conflict  = conflict_r;
  assign bus.range_err = range_r;
  assign bus.conf_cnt  = cnt_r;
endmodule

// File: tb/tb_bus_mux_reg.sv
// Scoreboard bench for bus_mux_reg (NREG=6, CNTW=2): driver pushes expected snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_bus_mux_reg;
  localparam int DW = 16, NREG = 6, SELW = 3, CNTW = 2;

  typedef struct {
    logic [15:0] buswires, bus_q;
    logic        vld;
    logic [1:0]  src;
    logic [2:0]  idx;
    logic        conflict, range_err;
    logic [1:0]  cnt;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_mux_if #(.DW(DW), .NREG(NREG), .SELW(SELW), .CNTW(CNTW)) bif ();
  bus_mux_reg #(.DW(DW), .NREG(NREG), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  snap_t q[$];
  int checks = 0, failures = 0;

  // Reference model state: what the registered outputs should read right now.
  logic [15:0] m_regs [NREG];
  logic [15:0] m_bus = '0;
  bit          m_vld = 0, m_conf = 0, m_rng = 0;
  int          m_src = 0, m_idx = 0, m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit de, input bit ge, input bit re,
                      input int sel, input bit clr, input logic [15:0] d,
                      input logic [15:0] a);
    snap_t e;
    int n;
    logic [15:0] w;
    @(posedge clk);
    #1;
    rst = r;
    bif.din = d; bif.aluout = a;
    bif.din_en = de; bif.gout = ge; bif.rout_en = re;
    bif.rout = 3'(sel); bif.clr_err = clr;
    for (int i = 0; i < NREG; i++) bif.regs[i*DW +: DW] = m_regs[i];
    if (r) begin
      m_bus = '0; m_vld = 0; m_src = 0; m_idx = 0; m_conf = 0; m_rng = 0; m_cnt = 0;
    end
    if (de) w = d;
    else if (ge) w = a;
    else if (re && sel < NREG) w = m_regs[sel];
    else w = '0;
    e.buswires = w; e.bus_q = m_bus; e.vld = m_vld; e.src = 2'(m_src);
    e.idx = 3'(m_idx); e.conflict = m_conf; e.range_err = m_rng; e.cnt = 2'(m_cnt);
    q.push_back(e);
    if (!r) begin
      n = int'(de) + int'(ge) + int'(re);
      m_vld = (n > 0);
      if (n > 0) begin
        m_bus = w;
        m_src = de ? 1 : ge ? 2 : 3;
        m_idx = (m_src == 3) ? sel : 0;
      end
      if (clr) begin m_conf = 0; m_rng = 0; m_cnt = 0; end
      if (n >= 2) begin
        m_conf = 1;
        if (m_cnt < (1 << CNTW) - 1) m_cnt++;
      end
      if (re && sel >= NREG) m_rng = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      snap_t e;
      e = q.pop_front();
      chk("buswires",  32'(bif.buswires),  32'(e.buswires));
      chk("bus_q",     32'(bif.bus_q),     32'(e.bus_q));
      chk("bus_vld",   32'(bif.bus_vld),   32'(e.vld));
      chk("src_q",     32'(bif.src_q),     32'(e.src));
      chk("idx_q",     32'(bif.idx_q),     32'(e.idx));
      chk("conflict",  32'(bif.conflict),  32'(e.conflict));
      chk("range_err", 32'(bif.range_err), 32'(e.range_err));
      chk("conf_cnt",  32'(bif.conf_cnt),  32'(e.cnt));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREG; i++) m_regs[i] = 16'(16'h1000 + i * 16'h0111);
    bif.din = '0; bif.aluout = '0; bif.regs = '0; bif.din_en = 0; bif.gout = 0;
    bif.rout_en = 0; bif.rout = '0; bif.clr_err = 0;

    // Reset held while din is being driven, then first transfer after release.
    step(1, 1, 0, 0, 0, 0, 16'hA5A5, 16'h0);
    step(1, 1, 0, 0, 0, 0, 16'hA5A5, 16'h0);
    step(0, 1, 0, 0, 0, 0, 16'hA5A5, 16'h0);
    idle(1);

    // Register drive then hold.
    m_regs[5] = 16'h1234;
    step(0, 0, 0, 1, 5, 0, 16'h0, 16'h0);
    idle(3);

    // Three-way conflict, then clear alone.
    step(0, 1, 1, 1, 3, 0, 16'h0001, 16'h0002);
    step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    idle(1);

    // Counter saturation, then clear coinciding with a conflict.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1, 0, 16'h0, 16'(16'h0100 + i));
    step(0, 1, 1, 0, 0, 1, 16'h0777, 16'h0888);
    step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);

    // Out-of-range select, then sweep the valid registers.
    step(0, 0, 0, 1, 7, 0, 16'h0, 16'h0);
    for (int i = 0; i < NREG; i++) step(0, 0, 0, 1, i, 0, 16'h0, 16'h0);
    step(0, 0, 0, 1, 6, 0, 16'h0, 16'h0);
    idle(1);

    // Async reset arriving between edges while the bus holds BEEF.
    step(0, 1, 0, 0, 0, 0, 16'hBEEF, 16'h0);
    idle(1);
    step(1, 1, 0, 0, 0, 0, 16'h5555, 16'h0);
    step(1, 0, 1, 0, 0, 0, 16'h0, 16'h6666);
    step(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    step(0, 0, 1, 0, 0, 0, 16'h0, 16'h7777);
    idle(1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = 16'($urandom);
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0), $urandom_range(0, 7),
           ($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom));
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
